// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b word type and fetch FSM state encoding.
package lc3b_types;
    typedef logic [15:0] lc3b_word;
    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} lc3b_fetch_state;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory port and IF/ID pipeline handshake.
interface fetch_stage_if;
    import lc3b_types::*;
    lc3b_word imem_address;
    logic     imem_read;
    lc3b_word imem_rdata;
    logic     imem_resp;
    logic     stall;
    logic     redirect;
    lc3b_word redirect_pc;
    logic     if_id_valid;
    lc3b_word if_id_ir;
    lc3b_word if_id_pc;
    modport master(output imem_address, imem_read, if_id_valid, if_id_ir, if_id_pc,
                   input imem_rdata, imem_resp, stall, redirect, redirect_pc);
    modport slave(input imem_address, imem_read, if_id_valid, if_id_ir, if_id_pc,
                  output imem_rdata, imem_resp, stall, redirect, redirect_pc);
endinterface

// File: rtl/fetch_skid.sv
// fetch_skid: single-entry buffer holding a fetched word while decode is stalled.
module fetch_skid
    import lc3b_types::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  logic     i_load,
    input  logic     i_clear,
    input  lc3b_word i_ir,
    input  lc3b_word i_pc,
    output lc3b_word o_ir,
    output lc3b_word o_pc,
    output logic     o_valid
);
    lc3b_word r_ir, r_pc;
    logic     r_valid;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ir    <= '0;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_ir    <= i_ir;
            r_pc    <= i_pc;
            r_valid <= 1'b1;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end
    assign o_ir    = r_ir;
    assign o_pc    = r_pc;
    assign o_valid = r_valid;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: LC-3b instruction fetch with skid buffer and redirect drain.
module fetch_stage
    import lc3b_types::*;
#(
    parameter lc3b_word RESET_PC = 16'h0000
) (
    input  logic           clk,
    input  logic           reset_n,
    fetch_stage_if.master  bus
);
    lc3b_fetch_state r_state, w_state_n;
    lc3b_word r_pc, w_pc_n, r_pending_pc, w_pending_n, r_ir, r_id_pc, w_pc_inc, w_skid_ir, w_skid_pc;
    logic r_armed, r_valid, w_valid_n, w_resp, w_free, w_load_id, w_from_skid;
    logic w_skid_load, w_skid_clear, w_skid_valid;
    // r_armed masks responses to a read abandoned by reset
    assign w_resp   = bus.imem_resp & r_armed;
    assign w_pc_inc = r_pc + 16'd2;
    assign w_free   = !r_valid || !bus.stall;
    fetch_skid u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_ir    (bus.imem_rdata),
        .i_pc    (w_pc_inc),
        .o_ir    (w_skid_ir),
        .o_pc    (w_skid_pc),
        .o_valid (w_skid_valid)
    );
    always_comb begin
        w_state_n    = r_state;
        w_pc_n       = r_pc;
        w_pending_n  = r_pending_pc;
        w_load_id    = 1'b0;
        w_from_skid  = 1'b0;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;
        case (r_state)
            FETCH: begin
                if (bus.redirect) begin
                    if (w_resp) w_pc_n = bus.redirect_pc;
                    else begin
                        w_pending_n = bus.redirect_pc;
                        w_state_n   = DRAIN;
                    end
                end else if (w_resp) begin
                    w_pc_n = w_pc_inc;
                    if (w_free) w_load_id = 1'b1;
                    else begin
                        w_skid_load = 1'b1;
                        w_state_n   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.redirect) begin
                    w_pc_n       = bus.redirect_pc;
                    w_skid_clear = 1'b1;
                    w_state_n    = FETCH;
                end else if (!bus.stall) begin
                    w_load_id    = w_skid_valid;
                    w_from_skid  = 1'b1;
                    w_skid_clear = 1'b1;
                    w_state_n    = FETCH;
                end
            end
            DRAIN: begin
                if (w_resp) begin
                    w_pc_n    = bus.redirect ? bus.redirect_pc : r_pending_pc;
                    w_state_n = FETCH;
                end else if (bus.redirect) w_pending_n = bus.redirect_pc;
            end
            default: w_state_n = FETCH;
        endcase
        w_valid_n = bus.redirect ? 1'b0 : w_load_id ? 1'b1 : !bus.stall ? 1'b0 : r_valid;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= FETCH;
            r_pc         <= RESET_PC;
            r_pending_pc <= '0;
            r_armed      <= 1'b0;
            r_valid      <= 1'b0;
            r_ir         <= '0;
            r_id_pc      <= '0;
        end else begin
            r_state      <= w_state_n;
            r_pc         <= w_pc_n;
            r_pending_pc <= w_pending_n;
            r_armed      <= 1'b1;
            r_valid      <= w_valid_n;
            if (w_load_id) begin
                r_ir    <= w_from_skid ? w_skid_ir : bus.imem_rdata;
                r_id_pc <= w_from_skid ? w_skid_pc : w_pc_inc;
            end
        end
    end
    assign bus.imem_read    = r_armed && (r_state != HOLD);
    assign bus.imem_address = r_pc;
    assign bus.if_id_valid  = r_valid;
    assign bus.if_id_ir     = r_ir;
    assign bus.if_id_pc     = r_id_pc;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: per-cycle vector table plus a scoreboard of delivered IF/ID words.
module tb_fetch_stage;
    typedef struct {
        logic        stall, redirect;
        logic [15:0] rpc;
        logic        resp;
        logic [15:0] rdata;
        logic        push;
        logic        e_read;
        logic [15:0] e_addr;
        logic        e_valid;
        logic        chk;
        logic [15:0] e_ir, e_pc;
    } vec_t;
    typedef struct {
        logic [15:0] ir, pc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errs = 0;
    int   checks = 0;
    vec_t v[$];
    exp_t sb[$];

    fetch_stage_if bus();
    fetch_stage #(.RESET_PC(16'h0000)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic rd, input logic [15:0] rpc,
                                input logic rs, input logic [15:0] dat, input logic pu,
                                input logic er, input logic [15:0] ea, input logic ev,
                                input logic ck, input logic [15:0] eir, input logic [15:0] epc);
        vec_t t;
        t.stall = st; t.redirect = rd; t.rpc = rpc; t.resp = rs; t.rdata = dat; t.push = pu;
        t.e_read = er; t.e_addr = ea; t.e_valid = ev; t.chk = ck; t.e_ir = eir; t.e_pc = epc;
        return t;
    endfunction

    initial begin
        exp_t e;
        bus.stall = 0; bus.redirect = 0; bus.redirect_pc = 0; bus.imem_resp = 0; bus.imem_rdata = 0;
        //      st rd rpc       rs dat       pu er addr      ev ck ir        pc
        v.push_back(mk(0,0,16'h0000,1,16'hDEAD,0,0,16'h0000,0,0,16'h0000,16'h0000)); // c0 resp ignored after reset
        v.push_back(mk(0,0,16'h0000,0,16'h0000,0,1,16'h0000,0,0,16'h0000,16'h0000));
        v.push_back(mk(0,0,16'h0000,1,16'h1220,1,1,16'h0000,0,0,16'h0000,16'h0000));
        v.push_back(mk(0,0,16'h0000,0,16'h0000,0,1,16'h0002,1,0,16'h0000,16'h0000));
        v.push_back(mk(0,0,16'h0000,1,16'h5260,1,1,16'h0002,0,0,16'h0000,16'h0000));
        v.push_back(mk(1,0,16'h0000,0,16'h0000,0,1,16'h0004,1,0,16'h0000,16'h0000)); // c5 stall
        v.push_back(mk(1,0,16'h0000,1,16'h0E05,1,1,16'h0004,1,0,16'h0000,16'h0000));
        v.push_back(mk(1,0,16'h0000,0,16'h0000,0,0,16'h0006,1,1,16'h5260,16'h0004)); // HOLD
        v.push_back(mk(1,0,16'h0000,0,16'h0000,0,0,16'h0006,1,0,16'h0000,16'h0000));
        v.push_back(mk(0,0,16'h0000,0,16'h0000,0,0,16'h0006,1,0,16'h0000,16'h0000));
        v.push_back(mk(0,0,16'h0000,0,16'h0000,0,1,16'h0006,1,0,16'h0000,16'h0000)); // c10
        v.push_back(mk(0,1,16'h0040,0,16'h0000,0,1,16'h0006,0,0,16'h0000,16'h0000));
        v.push_back(mk(0,0,16'h0000,0,16'h0000,0,1,16'h0006,0,0,16'h0000,16'h0000)); // DRAIN
        v.push_back(mk(0,0,16'h0000,1,16'hBAD1,0,1,16'h0006,0,0,16'h0000,16'h0000));
        v.push_back(mk(0,0,16'h0000,0,16'h0000,0,1,16'h0040,0,0,16'h0000,16'h0000));
        v.push_back(mk(0,0,16'h0000,1,16'h1111,0,1,16'h0040,0,0,16'h0000,16'h0000)); // c15 later flushed
        v.push_back(mk(1,1,16'h0080,1,16'h2222,0,1,16'h0042,1,0,16'h0000,16'h0000));
        v.push_back(mk(0,0,16'h0000,0,16'h0000,0,1,16'h0080,0,0,16'h0000,16'h0000));
        v.push_back(mk(0,1,16'hFFF0,0,16'h0000,0,1,16'h0080,0,0,16'h0000,16'h0000));
        v.push_back(mk(0,1,16'hFFFE,0,16'h0000,0,1,16'h0080,0,0,16'h0000,16'h0000)); // overwrite pending
        v.push_back(mk(0,0,16'h0000,1,16'hBAD2,0,1,16'h0080,0,0,16'h0000,16'h0000)); // c20
        v.push_back(mk(0,0,16'h0000,1,16'hF025,1,1,16'hFFFE,0,0,16'h0000,16'h0000)); // wrap
        v.push_back(mk(0,0,16'h0000,0,16'h0000,0,1,16'h0000,1,0,16'h0000,16'h0000));
        v.push_back(mk(0,0,16'h0000,1,16'h3333,0,1,16'h0000,0,0,16'h0000,16'h0000));
        v.push_back(mk(1,0,16'h0000,1,16'h4444,0,1,16'h0002,1,0,16'h0000,16'h0000));
        v.push_back(mk(1,1,16'h0100,0,16'h0000,0,0,16'h0004,1,0,16'h0000,16'h0000)); // c25 redirect in HOLD
        v.push_back(mk(0,0,16'h0000,0,16'h0000,0,1,16'h0100,0,0,16'h0000,16'h0000));
        v.push_back(mk(0,1,16'h0200,0,16'h0000,0,1,16'h0100,0,0,16'h0000,16'h0000));
        v.push_back(mk(0,1,16'h0300,1,16'h0000,0,1,16'h0100,0,0,16'h0000,16'h0000)); // redirect with resp in DRAIN
        v.push_back(mk(0,0,16'h0000,0,16'h0000,0,1,16'h0300,0,0,16'h0000,16'h0000));
        v.push_back(mk(0,0,16'h0000,1,16'h5555,1,1,16'h0300,0,0,16'h0000,16'h0000)); // c30 back-to-back
        v.push_back(mk(0,0,16'h0000,1,16'h6666,1,1,16'h0302,1,0,16'h0000,16'h0000));
        v.push_back(mk(0,0,16'h0000,0,16'h0000,0,1,16'h0304,1,0,16'h0000,16'h0000));
        v.push_back(mk(0,0,16'h0000,0,16'h0000,0,1,16'h0304,0,1,16'h6666,16'h0304));

        #2;
        chk("rst read",  {15'd0, bus.imem_read},   16'h0000);
        chk("rst addr",  bus.imem_address,         16'h0000);
        chk("rst valid", {15'd0, bus.if_id_valid}, 16'h0000);
        chk("rst ir",    bus.if_id_ir,             16'h0000);
        chk("rst pc",    bus.if_id_pc,             16'h0000);
        @(negedge clk);
        reset_n = 1;
        for (int i = 0; i < v.size(); i++) begin
            bus.stall = v[i].stall; bus.redirect = v[i].redirect; bus.redirect_pc = v[i].rpc;
            bus.imem_resp = v[i].resp; bus.imem_rdata = v[i].rdata;
            if (v[i].push) begin
                e.ir = v[i].rdata;
                e.pc = v[i].e_addr + 16'd2;
                sb.push_back(e);
            end
            chk($sformatf("c%0d read", i),  {15'd0, bus.imem_read},   {15'd0, v[i].e_read});
            chk($sformatf("c%0d addr", i),  bus.imem_address,         v[i].e_addr);
            chk($sformatf("c%0d valid", i), {15'd0, bus.if_id_valid}, {15'd0, v[i].e_valid});
            if (v[i].chk) begin
                chk($sformatf("c%0d hold ir", i), bus.if_id_ir, v[i].e_ir);
                chk($sformatf("c%0d hold pc", i), bus.if_id_pc, v[i].e_pc);
            end
            if (bus.if_id_valid && !v[i].stall) begin
                if (sb.size() == 0) begin
                    checks++; errs++;
                    $display("FAIL c%0d unexpected delivery: got ir %h pc %h want none", i, bus.if_id_ir, bus.if_id_pc);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("c%0d sb ir", i), bus.if_id_ir, e.ir);
                    chk($sformatf("c%0d sb pc", i), bus.if_id_pc, e.pc);
                end
            end
            @(negedge clk);
        end
        chk("sb drained", 16'(sb.size()), 16'h0000);
        bus.stall = 0; bus.imem_resp = 0; bus.redirect = 1; bus.redirect_pc = 16'h0700;
        @(negedge clk);
        bus.redirect = 0;
        chk("drain read", {15'd0, bus.imem_read}, 16'h0001);
        chk("drain addr", bus.imem_address,       16'h0304);
        #2 reset_n = 0;
        #1;
        chk("async read",  {15'd0, bus.imem_read},   16'h0000);
        chk("async addr",  bus.imem_address,         16'h0000);
        chk("async valid", {15'd0, bus.if_id_valid}, 16'h0000);
        chk("async ir",    bus.if_id_ir,             16'h0000);
        chk("async pc",    bus.if_id_pc,             16'h0000);
        @(negedge clk);
        reset_n = 1;
        bus.imem_resp = 1; bus.imem_rdata = 16'hBEEF;
        chk("restart read0", {15'd0, bus.imem_read}, 16'h0000);
        @(negedge clk);
        bus.imem_resp = 0;
        chk("restart read1", {15'd0, bus.imem_read},   16'h0001);
        chk("restart addr",  bus.imem_address,         16'h0000);
        chk("restart valid", {15'd0, bus.if_id_valid}, 16'h0000);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 16'h0000, PC loaded on reset.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 imem_address  out  16  lc3b_word fetch address (current PC).
REQ-005 imem_read  out  1  instruction read request.
REQ-006 imem_rdata  in  16  instruction word; valid when imem_resp=1.
REQ-007 imem_resp  in  1  one-cycle read-complete pulse.
REQ-008 stall  in  1  decode stage cannot accept a new instruction this cycle.
REQ-009 redirect  in  1  taken branch/JMP/JSR/TRAP from a later stage.
REQ-010 redirect_pc  in  16  target PC, valid when redirect=1.
REQ-011 if_id_valid  out  1  IF/ID register holds a live instruction.
REQ-012 if_id_ir  out  16  fetched instruction word.
REQ-013 if_id_pc  out  16  fetch address + 2 (LC-3b incremented PC).

Function
REQ-014 FSM states SHALL be FETCH, HOLD and DRAIN.
REQ-015 imem_read SHALL be 1 in FETCH and DRAIN and 0 in HOLD; imem_address SHALL stay stable until imem_resp.
REQ-016 The output slot is free when if_id_valid=0 or stall=0.
REQ-017 FETCH, imem_resp=1, redirect=0, slot free: load if_id_ir=imem_rdata, if_id_pc=pc+2, if_id_valid=1, pc<=pc+2, stay FETCH; back-to-back requests, address changes the next cycle.
REQ-018 FETCH, imem_resp=1, redirect=0, slot not free: capture word and pc+2 into the skid entry, pc<=pc+2, go HOLD.
REQ-019 HOLD, stall=0: move the skid entry into IF/ID, go FETCH.
REQ-020 FETCH, imem_resp=1, redirect=1: discard the word, pc<=redirect_pc, stay FETCH.
REQ-021 FETCH, imem_resp=0, redirect=1: save redirect_pc in pending_pc, go DRAIN; imem_address keeps the old PC.
REQ-022 DRAIN, imem_resp=1: discard the word, pc<=pending_pc, go FETCH; a new redirect in DRAIN overwrites pending_pc, or supplies the PC directly if it coincides with imem_resp.
REQ-023 HOLD, redirect=1: discard the skid entry, pc<=redirect_pc, go FETCH.
REQ-024 Any redirect SHALL clear if_id_valid the next cycle; redirect has priority over stall and over imem_resp.
REQ-025 stall=0 with no new word loaded: if_id_valid SHALL go 0; ir/pc hold their last value.
REQ-026 stall=1 with if_id_valid=1 and no redirect: if_id_ir, if_id_pc and if_id_valid SHALL hold.
REQ-027 PC arithmetic is 16-bit modulo; 16'hFFFE+2 wraps to 16'h0000.

Reset
REQ-028 reset_n=0 SHALL immediately set state=FETCH, pc=RESET_PC, pending_pc=0, skid cleared, if_id_valid=0, if_id_ir=0, if_id_pc=0.
REQ-029 imem_read SHALL be forced to 0 while reset_n=0; the first request issues on the first clk edge after release.
REQ-030 Reset mid-request abandons the outstanding read; an imem_resp in the first cycle after release SHALL be ignored.

Structure
REQ-031 lc3b_word SHALL come from lc3b_types; lc3b_fetch_state (FETCH/HOLD/DRAIN enum) SHALL be added to lc3b_types.
REQ-032 The single-entry skid buffer SHALL be a sub-module named fetch_skid (ir, pc, valid; load/clear inputs).

Verification
REQ-033 Reset with RESET_PC=16'h0000, imem_resp every 2nd cycle with words 16'h1220, 16'h5260 -> addresses 0, 2; IF/ID shows ir 16'h1220 with pc 16'h0002, then ir 16'h5260 with pc 16'h0004.
REQ-034 stall=1 for 3 cycles while the next response 16'h0E05 arrives -> HOLD, imem_read=0, IF/ID unchanged; on stall=0 IF/ID shows ir 16'h0E05; fetch resumes at the next PC.
REQ-035 redirect=1 with redirect_pc=16'h0040 while a read is outstanding -> DRAIN, address unchanged until resp, word discarded, next address 16'h0040, if_id_valid=0 for at least one cycle.
REQ-036 redirect coincident with imem_resp and stall=1 -> word dropped, if_id_valid=0, next address = redirect_pc.
REQ-037 PC=16'hFFFE, response 16'hF025 -> if_id_pc=16'h0000, next imem_address=16'h0000.
REQ-038 Assert reset_n=0 mid-DRAIN -> all outputs are reset values in the same cycle; fetch restarts at RESET_PC.
